// File: rtl/jogo_pkg.sv
// Shared state codes and sizing constants for the memory-sequence game control unit.
package jogo_pkg;

  localparam int N_RODADAS_DEF = 16;
  localparam int AW            = 4;

  // Codes are shown directly on the debug 7-segment display
  typedef enum logic [3:0] {
    ST_INICIAL        = 4'h0,
    ST_PREPARACAO     = 4'h1,
    ST_ESPERA_JOGADA  = 4'h2,
    ST_REGISTRA       = 4'h3,
    ST_COMPARACAO     = 4'h4,
    ST_PROXIMA_JOGADA = 4'h5,
    ST_PROXIMA_RODADA = 4'h6,
    ST_FIM_GANHOU     = 4'hA,
    ST_FIM_TIMEOUT    = 4'hD,
    ST_FIM_ERROU      = 4'hE
  } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// Per-move timeout counter: counts while conta is high, fim flags the last allowed cycle.
module contador_timeout #(
  parameter int TW             = 28,
  parameter int TIMEOUT_CICLOS = 150000000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign fim = (cnt == LIMITE);

endmodule

// File: rtl/sequenciador_jogo.sv
// Control unit for the Simon-style game: sequences rounds/moves and decides win, error or timeout.
// Optional per-move timeout is built only when SEQUENCIADOR_TIMEOUT_EN is defined.
module sequenciador_jogo
  import jogo_pkg::*;
#(
  parameter int N_RODADAS      = N_RODADAS_DEF,
  parameter int TIMEOUT_CICLOS = 150000000,
  parameter int TW             = 28
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          jogar,
  input  logic          tem_jogada,
  input  logic          jogada_correta,
  output logic [AW-1:0] endereco,
  output logic [AW-1:0] rodada,
  output logic          registra_jogada,
  output logic          zera_jogada,
  output logic          pronto,
  output logic          ganhou,
  output logic          perdeu,
  output logic [3:0]    db_estado,
  output logic          db_timeout
);

  localparam logic [AW-1:0] ULTIMA_RODADA = AW'(N_RODADAS - 1);

  estado_t estado, estado_prox;
  logic    tem_prev;
  logic    borda;
  logic    conta_to;
  logic    zera_to;

  // A held button produces a single move: only the rising edge counts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tem_prev <= 1'b0;
    else        tem_prev <= tem_jogada;
  end

  assign borda = tem_jogada & ~tem_prev;

`ifdef SEQUENCIADOR_TIMEOUT_EN
  logic fim_to;

  contador_timeout #(
    .TW             (TW),
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera_to),
    .conta (conta_to),
    .fim   (fim_to)
  );
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= ST_INICIAL;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox     = estado;
    registra_jogada = 1'b0;
    zera_jogada     = 1'b0;
    pronto          = 1'b0;
    ganhou          = 1'b0;
    perdeu          = 1'b0;
    db_timeout      = 1'b0;
    conta_to        = 1'b0;
    zera_to         = 1'b0;
    case (estado)
      ST_INICIAL: begin
        if (jogar) estado_prox = ST_PREPARACAO;
      end
      ST_PREPARACAO: begin
        zera_jogada = 1'b1;
        zera_to     = 1'b1;
        estado_prox = ST_ESPERA_JOGADA;
      end
      ST_ESPERA_JOGADA: begin
        conta_to = 1'b1;
        // A press in the last allowed cycle still counts as a move
        if (borda) estado_prox = ST_REGISTRA;
`ifdef SEQUENCIADOR_TIMEOUT_EN
        else if (fim_to) estado_prox = ST_FIM_TIMEOUT;
`endif
      end
      ST_REGISTRA: begin
        registra_jogada = 1'b1;
        zera_to         = 1'b1;
        estado_prox     = ST_COMPARACAO;
      end
      ST_COMPARACAO: begin
        if (!jogada_correta)               estado_prox = ST_FIM_ERROU;
        else if (endereco < rodada)        estado_prox = ST_PROXIMA_JOGADA;
        else if (rodada == ULTIMA_RODADA)  estado_prox = ST_FIM_GANHOU;
        else                               estado_prox = ST_PROXIMA_RODADA;
      end
      ST_PROXIMA_JOGADA: begin
        estado_prox = ST_ESPERA_JOGADA;
      end
      ST_PROXIMA_RODADA: begin
        zera_jogada = 1'b1;
        estado_prox = ST_ESPERA_JOGADA;
      end
      ST_FIM_GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
        if (jogar) estado_prox = ST_PREPARACAO;
      end
      ST_FIM_ERROU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
        if (jogar) estado_prox = ST_PREPARACAO;
      end
`ifdef SEQUENCIADOR_TIMEOUT_EN
      ST_FIM_TIMEOUT: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
        if (jogar) estado_prox = ST_PREPARACAO;
      end
`endif
      default: estado_prox = ST_INICIAL;
    endcase
  end

  // Round never passes the last index: the win check in comparacao precedes any increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco <= '0;
      rodada   <= '0;
    end else begin
      case (estado)
        ST_PREPARACAO: begin
          endereco <= '0;
          rodada   <= '0;
        end
        ST_PROXIMA_JOGADA: endereco <= endereco + AW'(1);
        ST_PROXIMA_RODADA: begin
          rodada   <= rodada + AW'(1);
          endereco <= '0;
        end
        default: ;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_sequenciador_jogo.sv
// Scoreboard bench for sequenciador_jogo: stimulus queues expected registra/end events, a monitor checks them.
module tb_sequenciador_jogo;

  localparam int NR = 4;
  localparam int TO = 100;

  typedef struct {
    bit         is_fim;
    logic [3:0] end_e;
    logic [3:0] rod_e;
    logic [3:0] est_e;
    logic       gan_e;
    logic       per_e;
    logic       to_e;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic       tem_jogada;
  logic       jogada_correta;
  logic [3:0] endereco;
  logic [3:0] rodada;
  logic       registra_jogada;
  logic       zera_jogada;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic [3:0] db_estado;
  logic       db_timeout;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   n_pulsos = 0;
  logic pronto_q = 1'b0;

  always #5 clock = ~clock;

  sequenciador_jogo #(
    .N_RODADAS      (NR),
    .TIMEOUT_CICLOS (TO),
    .TW             (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .jogar           (jogar),
    .tem_jogada      (tem_jogada),
    .jogada_correta  (jogada_correta),
    .endereco        (endereco),
    .rodada          (rodada),
    .registra_jogada (registra_jogada),
    .zera_jogada     (zera_jogada),
    .pronto          (pronto),
    .ganhou          (ganhou),
    .perdeu          (perdeu),
    .db_estado       (db_estado),
    .db_timeout      (db_timeout)
  );

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push_pulso(input logic [3:0] e, input logic [3:0] r);
    exp_t x;
    x = '{is_fim: 1'b0, end_e: e, rod_e: r, est_e: 4'h3, gan_e: 1'b0, per_e: 1'b0, to_e: 1'b0};
    sb.push_back(x);
  endtask

  task automatic push_fim(input logic [3:0] est, input logic [3:0] e, input logic [3:0] r,
                          input logic g, input logic p, input logic t);
    exp_t x;
    x = '{is_fim: 1'b1, end_e: e, rod_e: r, est_e: est, gan_e: g, per_e: p, to_e: t};
    sb.push_back(x);
  endtask

  // One move: 5 cycles pressed, 5 released
  task automatic aperta();
    tem_jogada = 1'b1;
    repeat (5) tick();
    tem_jogada = 1'b0;
    repeat (5) tick();
  endtask

  task automatic reinicia();
    jogar = 1'b1;
    tick();
    chk("restart_prep", db_estado, 4'h1);
    chk("restart_pronto", pronto, 1'b0);
    chk("restart_ganhou", ganhou, 1'b0);
    tick();
    chk("restart_espera", db_estado, 4'h2);
    chk("restart_rodada", rodada, 4'h0);
    chk("restart_endereco", endereco, 4'h0);
    jogar = 1'b0;
  endtask

  // Monitor: registra pulses and pronto rising edges pop the scoreboard
  always @(negedge clock) begin
    exp_t x;
    if (registra_jogada) begin
      n_pulsos++;
      if (sb.size() == 0) chk("sb_unexpected_pulse", 32'd1, 32'd0);
      else begin
        x = sb.pop_front();
        chk("pulse_kind", {31'd0, x.is_fim}, 32'd0);
        chk("pulse_endereco", endereco, x.end_e);
        chk("pulse_rodada", rodada, x.rod_e);
      end
    end
    if (pronto && !pronto_q) begin
      if (sb.size() == 0) chk("sb_unexpected_fim", 32'd1, 32'd0);
      else begin
        x = sb.pop_front();
        chk("fim_kind", {31'd0, x.is_fim}, 32'd1);
        chk("fim_estado", db_estado, x.est_e);
        chk("fim_endereco", endereco, x.end_e);
        chk("fim_rodada", rodada, x.rod_e);
        chk("fim_ganhou", ganhou, x.gan_e);
        chk("fim_perdeu", perdeu, x.per_e);
        chk("fim_timeout", db_timeout, x.to_e);
      end
    end
    pronto_q = pronto;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;
    reset = 1'b0; jogar = 1'b0; tem_jogada = 1'b0; jogada_correta = 1'b1;
    tick();
    chk("rst_estado", db_estado, 4'h0);
    chk("rst_endereco", endereco, 4'h0);
    chk("rst_rodada", rodada, 4'h0);
    chk("rst_saidas", {pronto, ganhou, perdeu, db_timeout, registra_jogada, zera_jogada}, 6'b0);
    reset = 1'b1;
    tick();
    chk("idle_estado", db_estado, 4'h0);

    // Start: jogar held for 5 cycles
    jogar = 1'b1;
    tick();
    chk("start_prep", db_estado, 4'h1);
    chk("start_zera", zera_jogada, 1'b1);
    tick();
    chk("start_espera", db_estado, 4'h2);
    repeat (3) tick();
    chk("start_hold_espera", db_estado, 4'h2);
    chk("start_pronto", {pronto, ganhou, perdeu}, 3'b0);
    jogar = 1'b0;

    // Full win with 4 rounds: 1+2+3+4 = 10 moves
    n0 = n_pulsos;
    for (int r = 0; r < NR; r++) begin
      for (int e = 0; e <= r; e++) begin
        push_pulso(4'(e), 4'(r));
        if (r == NR - 1 && e == r) push_fim(4'hA, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0);
        aperta();
      end
    end
    chk("win_pulses", n_pulsos - n0, 10);
    chk("win_estado", db_estado, 4'hA);
    chk("win_flags", {pronto, ganhou, perdeu}, 3'b110);

    reinicia();

    // Wrong move: round index 2, move index 1
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e <= r; e++) begin
        push_pulso(4'(e), 4'(r));
        if (r == 2 && e == 1) begin
          push_fim(4'hE, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0);
          jogada_correta = 1'b0;
        end
        aperta();
        if (r == 2 && e == 1) break;
      end
      if (db_estado == 4'hE) break;
    end
    jogada_correta = 1'b1;
    chk("err_estado", db_estado, 4'hE);
    chk("err_flags", {pronto, ganhou, perdeu}, 3'b101);
    chk("err_endereco", endereco, 4'h1);

    reinicia();

    // Held button: 50 cycles high is a single move
    n0 = n_pulsos;
    push_pulso(4'd0, 4'd0);
    tem_jogada = 1'b1;
    repeat (50) tick();
    tem_jogada = 1'b0;
    repeat (5) tick();
    chk("held_pulses", n_pulsos - n0, 1);
    chk("held_rodada", rodada, 4'h1);

    push_pulso(4'd0, 4'd1); aperta();
    push_pulso(4'd1, 4'd1); aperta();
    push_pulso(4'd0, 4'd2); aperta();
    push_pulso(4'd1, 4'd2); aperta();
    push_pulso(4'd2, 4'd2);
    tem_jogada = 1'b1;
    tick();
    n = 0;
    while (db_estado != 4'h2 && n < 10) begin
      tick();
      n++;
    end
    chk("r3_enter_espera", db_estado, 4'h2);
    chk("r3_rodada", rodada, 4'h3);
    chk("r3_endereco", endereco, 4'h0);
    tem_jogada = 1'b0;

`ifdef SEQUENCIADOR_TIMEOUT_EN
    push_fim(4'hD, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (db_estado != 4'hD && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_flags", {db_timeout, perdeu, pronto}, 3'b111);
    reinicia();
    // Press lands exactly when the counter sits at TO-1
    repeat (TO - 1) tick();
    chk("edge_tie_espera", db_estado, 4'h2);
    push_pulso(4'd0, 4'd0);
    tem_jogada = 1'b1;
    tick();
    chk("edge_tie_registra", db_estado, 4'h3);
`else
    repeat (1000) tick();
    chk("no_timeout_espera", db_estado, 4'h2);
    chk("no_timeout_flags", {db_timeout, perdeu, pronto}, 3'b000);
    push_pulso(4'd0, 4'd3);
    tem_jogada = 1'b1;
    tick();
    chk("late_press_registra", db_estado, 4'h3);
`endif

    // Async reset while in comparacao takes effect before the next edge
    tick();
    chk("pre_rst_comparacao", db_estado, 4'h4);
    reset = 1'b0;
    #1;
    chk("async_rst_estado", db_estado, 4'h0);
    chk("async_rst_regs", {endereco, rodada}, 8'h00);
    tem_jogada = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", db_estado, 4'h0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
